fib_seq_ctrl: RTL and testbench
===============================

// Module: fib_seq_ctrl
// PURPOSE
// - Sequencer FSM for the Fibonacci datapath. That datapath is built from mux logic cells with two
//   registers, A and B, and one shared adder.
// - Accepts a start request with an index n and drives the datapath selects and load enables so that
//   register A ends holding F(n).
// - Reports busy/done to the host.
// - Holds no datapath registers; it only counts iterations and sequences the loads.
// PARAMETERS
// - NW  5  width of the index n and of the step counter; max n = 2**NW-1
// PORTS
// - clk    in   1   rising-edge clock
// - rst_n  in   1   asynchronous active-low reset
// - start  in   1   request; sampled only in IDLE
// - n      in   NW  Fibonacci index; captured when start is accepted
// - busy   out  1   1 in INIT, STEP and DONE
// - done   out  1   one-cycle pulse: A holds F(n)
// - ld_init out 1   datapath loads constants A<=0, B<=1
// - ld_step out 1   datapath loads A<=B, B<=A+B
// - sel_a  out  1   A-input mux select: 0=constant 0, 1=B
// - sel_b  out  1   B-input mux select: 0=constant 1, 1=adder sum
// - cnt    out  NW  steps remaining (captured n, decremented per step)
// BEHAVIOUR
// - Reset (rst_n=0, async): state=IDLE; busy, done, ld_init, ld_step, sel_a, sel_b = 0; cnt=0.
//   Reset asserted mid-operation aborts immediately; the datapath contents are don't-care.
// - States: IDLE, INIT, STEP, DONE (registered; all outputs are decoded from registered state).
// - IDLE: start=1 -> cnt<=n, go to INIT. start=0 -> stay.
// - INIT (1 cycle): ld_init=1, sel_a=0, sel_b=0. cnt==0 -> DONE, else -> STEP.
// - STEP: ld_step=1, sel_a=1, sel_b=1; cnt<=cnt-1.
//   - cnt==1 on this cycle -> DONE next; else stay in STEP.
//   - Exactly n STEP cycles are issued per request.
// - DONE (1 cycle): done=1, busy=1, no loads; -> IDLE.
// - Latency: start accepted at edge k; INIT in cycle k+1; STEP in cycles k+2..k+n+1; done in cycle k+n+2.
//   For n=0, done is in cycle k+2.
// - start while busy=1 is ignored; no queueing.
// - start held high through DONE restarts in the first IDLE cycle; back-to-back requests have a 1-cycle IDLE gap.
// - ld_init and ld_step are never high in the same cycle; sel_a==sel_b in every cycle.
// - cnt never wraps: the decrement happens only in STEP, where cnt>=1.
// - n changes after acceptance have no effect.
// CONFIGURATION
// - FIB_CTRL_OVF_EN defined:
//   - Adds input ovf (1, carry out of the datapath adder) and output err (1).
//   - ovf is sampled in STEP only. ovf=1 -> the FSM goes to DONE next cycle, skipping the remaining steps.
//   - err<=1 with the done pulse; err stays 1 until the next start is accepted, then clears.
//   - Reset clears err.
// - FIB_CTRL_OVF_EN undefined: no ovf/err ports; the step count is always n.
// TESTING
// - Reset with start=1, then release rst_n: all outputs 0, state stays IDLE until the first clk edge
//   with rst_n=1.
// - n=5 with start pulsed:
//   - 1 INIT cycle, then 5 STEP cycles with cnt 5,4,3,2,1.
//   - done pulse at start+7 cycles.
//   - A behavioural datapath model reads A=5.
// - n=0: INIT, then done on the next cycle, no ld_step. Model reads A=0.
// - n=31 (NW=5): 31 steps. Model with a 32-bit adder reads A=1346269.
// - start pulsed during STEP, and start held high: no restart while busy; a new INIT follows 1 IDLE cycle
//   after done.
// - rst_n=0 asserted mid-STEP: outputs 0 asynchronously (before the next edge); after release, n=3
//   completes normally with A=2.
// - With FIB_CTRL_OVF_EN: NW=5, 8-bit model adder, n=20.
//   - ovf rises at step 13 (F(14)=377>255), causing early DONE with err=1.
//   - The next start with n=4 clears err and yields A=3.

Source files
------------

// File: rtl/fib_seq_ctrl.sv
// ---------------------------------------------------------------------------
// fib_seq_ctrl
//
// Sequencer for a two-register Fibonacci datapath (registers A and B sharing
// one adder). On an accepted start it issues one INIT load (A<=0, B<=1) and
// then n STEP loads (A<=B, B<=A+B), so that A ends holding F(n). After that
// it raises a one-cycle done pulse. It holds no datapath state of its own;
// it only counts the remaining steps and sequences the load strobes.
//
// Parameters
//   NW       width of the index n and of the step counter (max n = 2**NW-1)
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    request, sampled only while idle
//   n        Fibonacci index, captured when start is accepted
//   busy     high in INIT, STEP and DONE
//   done     one-cycle pulse: A holds the result
//   ld_init  datapath loads A<=0, B<=1
//   ld_step  datapath loads A<=B, B<=A+B
//   sel_a    A-input mux select: 0 = constant 0, 1 = B
//   sel_b    B-input mux select: 0 = constant 1, 1 = adder sum
//   cnt      steps remaining
//
// Optional feature, enabled by defining FIB_CTRL_OVF_EN:
//   ovf      (in)  carry out of the datapath adder, sampled during STEP;
//                  ends the sequence early
//   err      (out) set with the done pulse of an overflowed run, cleared
//                  when the next start is accepted
// ---------------------------------------------------------------------------
module fib_seq_ctrl #(
  parameter int NW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [NW-1:0] n,
`ifdef FIB_CTRL_OVF_EN
  input  logic          ovf,
  output logic          err,
`endif
  output logic          busy,
  output logic          done,
  output logic          ld_init,
  output logic          ld_step,
  output logic          sel_a,
  output logic          sel_b,
  output logic [NW-1:0] cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INIT = 2'd1,
    S_STEP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [NW-1:0] cnt_nxt;
  logic          ovf_stop;

`ifdef FIB_CTRL_OVF_EN
  assign ovf_stop = ovf;
`else
  assign ovf_stop = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_INIT;
          cnt_nxt   = n;
        end
      end
      S_INIT: begin
        // n == 0 needs no steps: A already holds F(0) after the INIT load.
        state_nxt = (cnt == '0) ? S_DONE : S_STEP;
      end
      S_STEP: begin
        // cnt >= 1 whenever STEP is entered, so this never wraps.
        cnt_nxt = cnt - NW'(1);
        if (cnt == NW'(1) || ovf_stop) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

`ifdef FIB_CTRL_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (state == S_IDLE && start) begin
      err <= 1'b0;
    end else if (state == S_STEP && ovf) begin
      // Lands together with the transition into DONE, so err rises with done.
      err <= 1'b1;
    end
  end
`endif

  // All strobes decode straight from the registered state, so reset clears
  // them without waiting for a clock edge.
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign ld_init = (state == S_INIT);
  assign ld_step = (state == S_STEP);
  assign sel_a   = (state == S_STEP);
  assign sel_b   = (state == S_STEP);

endmodule

// File: tb/tb_fib_seq_ctrl.sv
module tb_fib_seq_ctrl;

  localparam int NW = 5;
`ifdef FIB_CTRL_OVF_EN
  localparam logic [31:0] MASK = 32'h0000_00FF;
`else
  localparam logic [31:0] MASK = 32'hFFFF_FFFF;
`endif

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [NW-1:0] n     = '0;
  logic          busy, done, ld_init, ld_step, sel_a, sel_b;
  logic [NW-1:0] cnt;
  logic          err_w;
  logic          ovf_w;

  // Behavioural datapath: registers A and B driven by the sequencer strobes.
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

`ifdef FIB_CTRL_OVF_EN
  assign ovf_w = ld_step && ((A + B) > 32'd255);
`else
  assign ovf_w = 1'b0;
  assign err_w = 1'b0;
`endif

  fib_seq_ctrl #(.NW(NW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .n       (n),
`ifdef FIB_CTRL_OVF_EN
    .ovf     (ovf_w),
    .err     (err_w),
`endif
    .busy    (busy),
    .done    (done),
    .ld_init (ld_init),
    .ld_step (ld_step),
    .sel_a   (sel_a),
    .sel_b   (sel_b),
    .cnt     (cnt)
  );

  always @(posedge clk) begin
    if (ld_init || ld_step) begin
      A <= sel_a ? B : 32'd0;
      B <= sel_b ? ((A + B) & MASK) : 32'd1;
    end
  end

  // ---------------- reference model ----------------
  function automatic int unsigned fib(input int k);
    int unsigned a = 0;
    int unsigned b = 1;
    int unsigned t;
    for (int i = 0; i < k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Number of steps actually issued for index nv, and whether an adder
  // overflow cut the run short (step i produces F(i+1)).
  function automatic int steps_for(input int nv);
`ifdef FIB_CTRL_OVF_EN
    for (int i = 1; i <= nv; i++) if (fib(i + 1) > 255) return i;
`endif
    return nv;
  endfunction

  function automatic bit hit_for(input int nv);
`ifdef FIB_CTRL_OVF_EN
    for (int i = 1; i <= nv; i++) if (fib(i + 1) > 255) return 1'b1;
`endif
    return 1'b0;
  endfunction

  typedef struct {
    logic          busy, done, ld_init, ld_step, sel, err;
    logic [NW-1:0] cnt;
    int            steps;
  } exp_t;

  exp_t          q[$];          // expected outputs, one entry per busy cycle
  logic [NW-1:0] idle_cnt = '0;
  logic          idle_err = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model
    exp_t e;
    int   st;
    bit   h;
    if (!rst_n) begin
      q.delete();
      idle_cnt <= '0;
      idle_err <= 1'b0;
    end else if (q.size() > 0) begin
      if (q[0].done) begin
        idle_cnt <= q[0].cnt;
        idle_err <= q[0].err;
      end
      void'(q.pop_front());
    end else if (start) begin
      st = steps_for(int'(n));
      h  = hit_for(int'(n));
      e.busy = 1; e.done = 0; e.ld_init = 1; e.ld_step = 0; e.sel = 0;
      e.err = 0; e.cnt = n; e.steps = st;
      q.push_back(e);
      for (int i = 0; i < st; i++) begin
        e.ld_init = 0; e.ld_step = 1; e.sel = 1;
        e.cnt = n - NW'(i);
        q.push_back(e);
      end
      e.ld_init = 0; e.ld_step = 0; e.sel = 0; e.done = 1;
      e.err = h; e.cnt = n - NW'(st);
      q.push_back(e);
      idle_err <= 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin : compare
    exp_t e;
    if (q.size() > 0) begin
      e = q[0];
    end else begin
      e.busy = 0; e.done = 0; e.ld_init = 0; e.ld_step = 0; e.sel = 0;
      e.err = idle_err; e.cnt = idle_cnt; e.steps = 0;
    end
    chk("busy",    32'(busy),    32'(e.busy));
    chk("done",    32'(done),    32'(e.done));
    chk("ld_init", 32'(ld_init), 32'(e.ld_init));
    chk("ld_step", 32'(ld_step), 32'(e.ld_step));
    chk("sel_a",   32'(sel_a),   32'(e.sel));
    chk("sel_b",   32'(sel_b),   32'(e.sel));
    chk("cnt",     32'(cnt),     32'(e.cnt));
    chk("err",     32'(err_w),   32'(e.err));
    if (e.done) chk("A_at_done", A, fib(e.steps) & MASK);
  end

  // ---------------- stimulus ----------------
  // Called in an idle cycle just after a negedge; returns at the done cycle.
  task automatic run_req(input int nv, input logic [31:0] exp_a,
                         input int exp_lat, input bit noisy);
    int lat = 0;
    start = 1'b1;
    n     = NW'(nv);
    while (lat < 80) begin
      @(negedge clk);
      lat++;
      if (done) break;
      start = noisy ? ($urandom_range(0, 2) == 0) : 1'b0;
      n     = NW'($urandom_range(0, 31));
    end
    start = 1'b0;
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("A_result", A, exp_a);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    int nv, st;
    #1 rst_n = 1'b0;
    start = 1'b1;
    n     = NW'(5);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_busy",    32'(busy),    32'd0);
    chk("rel_ld_init", 32'(ld_init), 32'd0);
    chk("rel_cnt",     32'(cnt),     32'd0);
    run_req(5, 32'd5, 7, 1'b0);

    @(negedge clk);
    run_req(0, 32'd0, 2, 1'b0);

`ifndef FIB_CTRL_OVF_EN
    @(negedge clk);
    run_req(31, 32'd1346269, 33, 1'b0);
`endif

    // Start pulsed while busy, then held high across several requests.
    @(negedge clk);
    run_req(6, fib(steps_for(6)) & MASK, steps_for(6) + 2, 1'b1);
    @(negedge clk);
    start = 1'b1;
    n     = NW'(4);
    repeat (20) begin
      @(negedge clk);
      n = NW'($urandom_range(0, 6));
    end
    start = 1'b0;
    @(negedge clk);
    wait_idle();

    // Asynchronous reset in the middle of STEP.
    @(negedge clk);
    start = 1'b1;
    n     = NW'(10);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy",    32'(busy),    32'd0);
    chk("arst_ld_step", 32'(ld_step), 32'd0);
    chk("arst_sel_a",   32'(sel_a),   32'd0);
    chk("arst_cnt",     32'(cnt),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_req(3, 32'd2, 5, 1'b0);

`ifdef FIB_CTRL_OVF_EN
    @(negedge clk);
    run_req(20, 32'd233, 15, 1'b0);
    chk("ovf_err_at_done", 32'(err_w), 32'd1);
    @(negedge clk);
    chk("ovf_err_sticky", 32'(err_w), 32'd1);
    run_req(4, 32'd3, 6, 1'b0);
    chk("ovf_err_cleared", 32'(err_w), 32'd0);
`endif

    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(1, 3)) @(negedge clk);
      nv = $urandom_range(0, 31);
      st = steps_for(nv);
      run_req(nv, fib(st) & MASK, st + 2, 1'b1);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
